// File: rtl/cdb_writeback.sv
// Common-data-bus write-back stage: round-robin arbitration of FU results into a single
// broadcast stage that also owns the register-status write port (issue writes take priority).
module cdb_writeback #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned REG_INDEX = 5,
  parameter int unsigned FU_INDEX  = 3,
  parameter int unsigned NUM_FU    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_FU-1:0]             fu_valid,
  output logic [NUM_FU-1:0]             fu_ready,
  input  logic [NUM_FU*WORD_SIZE-1:0]   fu_value,
  input  logic [NUM_FU*REG_INDEX-1:0]   fu_dest,
  input  logic                          iss_we,
  input  logic [REG_INDEX-1:0]          iss_num,
  input  logic [FU_INDEX-1:0]           iss_tag,
  output logic [REG_INDEX-1:0]          st_num,
  input  logic [FU_INDEX-1:0]           st_q,
  output logic                          cdb_valid,
  output logic [FU_INDEX-1:0]           cdb_tag,
  output logic [WORD_SIZE-1:0]          cdb_value,
  output logic [REG_INDEX-1:0]          ws,
  output logic [WORD_SIZE-1:0]          wd,
  output logic                          we,
  output logic [REG_INDEX-1:0]          ws_rs,
  output logic [FU_INDEX-1:0]           wd_rs,
  output logic                          we_rs
);

  localparam int unsigned PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  // Per-FU one-entry holding buffers
  logic [NUM_FU-1:0]    r_full;
  logic [WORD_SIZE-1:0] r_bval  [NUM_FU];
  logic [REG_INDEX-1:0] r_bdest [NUM_FU];

  // Round-robin pointer and broadcast stage
  logic [PTR_W-1:0]     r_ptr;
  logic                 r_sv;
  logic [FU_INDEX-1:0]  r_stag;
  logic [WORD_SIZE-1:0] r_sval;
  logic [REG_INDEX-1:0] r_sdest;

  logic [PTR_W-1:0]     w_cand [NUM_FU];
  logic                 w_any;
  logic [PTR_W-1:0]     w_gidx;
  logic [NUM_FU-1:0]    w_gnt;
  logic [FU_INDEX-1:0]  w_gtag;
  logic [PTR_W-1:0]     w_ptr_nxt;
  logic                 w_match;
  logic                 w_conflict;
  logic                 w_commit;
  logic                 w_adv;
  logic [NUM_FU-1:0]    w_accept;

  // Search order: pointer first, wrapping modulo NUM_FU
  always_comb begin
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      w_cand[k] = PTR_W'((32'(r_ptr) + k) % NUM_FU);
    end
  end

  always_comb begin
    w_any  = 1'b0;
    w_gidx = '0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      if (!w_any && r_full[w_cand[k]]) begin
        w_any  = 1'b1;
        w_gidx = w_cand[k];
      end
    end
  end

  assign w_gnt     = w_any ? (NUM_FU'(1) << w_gidx) : '0;
  assign w_gtag    = FU_INDEX'(w_gidx) + FU_INDEX'(1);
  assign w_ptr_nxt = (32'(w_gidx) == NUM_FU - 1) ? '0 : w_gidx + 1'b1;

  // A matching commit and a rename of a different register both need the status port
  assign w_match    = r_sv & (st_q == r_stag);
  assign w_conflict = w_match & iss_we & (iss_num != r_sdest);
  assign w_commit   = r_sv & ~w_conflict;
  assign w_adv      = ~r_sv | w_commit;

  assign fu_ready = ~r_full | (w_gnt & {NUM_FU{w_adv}});
  assign w_accept = fu_valid & fu_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full <= '0;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        r_bval[i]  <= '0;
        r_bdest[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        if (w_accept[i]) begin
          r_full[i]  <= 1'b1;
          r_bval[i]  <= fu_value[i*WORD_SIZE +: WORD_SIZE];
          r_bdest[i] <= fu_dest[i*REG_INDEX +: REG_INDEX];
        end else if (w_gnt[i] && w_adv) begin
          r_full[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr   <= '0;
      r_sv    <= 1'b0;
      r_stag  <= '0;
      r_sval  <= '0;
      r_sdest <= '0;
    end else if (w_adv) begin
      r_sv <= w_any;
      if (w_any) begin
        r_stag  <= w_gtag;
        r_sval  <= r_bval[w_gidx];
        r_sdest <= r_bdest[w_gidx];
        r_ptr   <= w_ptr_nxt;
      end
    end
  end

  assign st_num    = r_sdest;
  assign cdb_valid = w_commit;
  assign cdb_tag   = r_stag;
  assign cdb_value = r_sval;
  assign we        = w_commit & w_match;
  assign ws        = r_sdest;
  assign wd        = r_sval;

  always_comb begin
    we_rs = 1'b0;
    ws_rs = '0;
    wd_rs = '0;
    if (iss_we) begin
      we_rs = 1'b1;
      ws_rs = iss_num;
      wd_rs = iss_tag;
    end else if (w_commit && w_match) begin
      we_rs = 1'b1;
      ws_rs = r_sdest;
    end
  end

endmodule

// File: tb/tb_cdb_writeback.sv
// Bench for cdb_writeback: directed scenarios with literal expectations plus a per-cycle
// comparison against a behavioural model of the pending results and the broadcast stage.
module tb_cdb_writeback;
  localparam int W = 32;
  localparam int R = 5;
  localparam int F = 3;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   fu_valid = '0;
  logic [N-1:0]   fu_ready;
  logic [N*W-1:0] fu_value = '0;
  logic [N*R-1:0] fu_dest = '0;
  logic           iss_we = 1'b0;
  logic [R-1:0]   iss_num = '0;
  logic [F-1:0]   iss_tag = '0;
  logic [R-1:0]   st_num;
  logic [F-1:0]   st_q = '0;
  logic           cdb_valid;
  logic [F-1:0]   cdb_tag;
  logic [W-1:0]   cdb_value;
  logic [R-1:0]   ws;
  logic [W-1:0]   wd;
  logic           we;
  logic [R-1:0]   ws_rs;
  logic [F-1:0]   wd_rs;
  logic           we_rs;

  int n_cmp = 0;
  int n_bad = 0;

  cdb_writeback #(.WORD_SIZE(W), .REG_INDEX(R), .FU_INDEX(F), .NUM_FU(N)) dut (
    .clk(clk), .reset(reset),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_value(fu_value), .fu_dest(fu_dest),
    .iss_we(iss_we), .iss_num(iss_num), .iss_tag(iss_tag),
    .st_num(st_num), .st_q(st_q),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .ws(ws), .wd(wd), .we(we),
    .ws_rs(ws_rs), .wd_rs(wd_rs), .we_rs(we_rs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: one pending slot per FU, a broadcast stage, a round-robin start point
  typedef struct {
    bit           full;
    logic [W-1:0] val;
    logic [R-1:0] dest;
  } slot_t;

  slot_t        m_slot [N];
  bit           m_sv = 0;
  logic [F-1:0] m_tag = '0;
  logic [W-1:0] m_val = '0;
  logic [R-1:0] m_dest = '0;
  int           m_ptr = 0;

  function automatic void model_eval(output logic [N-1:0] rdy, output bit commit,
                                     output bit match, output int gidx, output bit adv);
    gidx = -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (gidx < 0 && m_slot[c].full) gidx = c;
    end
    match  = m_sv && (st_q == m_tag);
    commit = m_sv && !(match && iss_we && (iss_num != m_dest));
    adv    = !m_sv || commit;
    for (int i = 0; i < N; i++) rdy[i] = !m_slot[i].full || (gidx == i && adv);
  endfunction

  always @(negedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) m_slot[i].full = 0;
      m_sv = 0; m_tag = '0; m_val = '0; m_dest = '0; m_ptr = 0;
    end else begin
      logic [N-1:0] rdy, acc;
      bit commit, match, adv;
      int gidx;
      model_eval(rdy, commit, match, gidx, adv);
      chk("fu_ready", fu_ready, rdy);
      chk("cdb_valid", cdb_valid, commit);
      if (commit) begin
        chk("cdb_tag", cdb_tag, m_tag);
        chk("cdb_value", cdb_value, m_val);
      end
      chk("we", we, commit && match);
      if (commit && match) begin
        chk("ws", ws, m_dest);
        chk("wd", wd, m_val);
      end
      chk("we_rs", we_rs, iss_we || (commit && match));
      if (iss_we) begin
        chk("ws_rs_iss", ws_rs, iss_num);
        chk("wd_rs_iss", wd_rs, iss_tag);
      end else if (commit && match) begin
        chk("ws_rs_clr", ws_rs, m_dest);
        chk("wd_rs_clr", wd_rs, 0);
      end
      if (m_sv) chk("st_num", st_num, m_dest);
      // Advance to the state the coming rising edge produces; inputs are stable until then
      acc = fu_valid & rdy;
      if (adv) begin
        if (gidx >= 0) begin
          m_sv   = 1;
          m_tag  = F'(gidx + 1);
          m_val  = m_slot[gidx].val;
          m_dest = m_slot[gidx].dest;
          m_slot[gidx].full = 0;
          m_ptr  = (gidx + 1) % N;
        end else begin
          m_sv = 0;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          m_slot[i].full = 1;
          m_slot[i].val  = fu_value[i*W +: W];
          m_slot[i].dest = fu_dest[i*R +: R];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fu(input int i, input logic [W-1:0] v, input logic [R-1:0] d);
    fu_value[i*W +: W] = v;
    fu_dest[i*R +: R]  = d;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic single_result(input int fu, input logic [W-1:0] v, input logic [R-1:0] d,
                               input logic [F-1:0] q, input bit exp_wr, input string nm);
    st_q = q;
    set_fu(fu, v, d);
    fu_valid = N'(1) << fu;
    tick();
    fu_valid = '0;
    @(negedge clk);
    chk({nm, "_early_valid"}, cdb_valid, 0);
    tick();
    @(negedge clk);
    chk({nm, "_valid"}, cdb_valid, 1);
    chk({nm, "_tag"}, cdb_tag, fu + 1);
    chk({nm, "_value"}, cdb_value, v);
    chk({nm, "_we"}, we, exp_wr);
    chk({nm, "_we_rs"}, we_rs, exp_wr);
    if (exp_wr) begin
      chk({nm, "_ws"}, ws, d);
      chk({nm, "_wd"}, wd, v);
      chk({nm, "_ws_rs"}, ws_rs, d);
      chk({nm, "_wd_rs"}, wd_rs, 0);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc_cnt [N];
    logic [F-1:0] exp_tags [8];

    #1;
    chk("rst_fu_ready", fu_ready, 4'hF);
    chk("rst_cdb_valid", cdb_valid, 0);
    chk("rst_we", we, 0);
    chk("rst_we_rs", we_rs, 0);
    chk("rst_cdb_tag", cdb_tag, 0);
    chk("rst_cdb_value", cdb_value, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    single_result(1, 32'hAB, 5'd5, 3'd2, 1'b1, "single");
    single_result(0, 32'h33, 5'd3, 3'd4, 1'b0, "stale");

    // Round robin with all FUs offering continuously
    do_reset();
    st_q = '0;
    for (int i = 0; i < N; i++) begin
      set_fu(i, W'(32'h100 + i), R'(10 + i));
      acc_cnt[i] = 0;
    end
    exp_tags = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd2, 3'd3, 3'd4};
    fu_valid = '1;
    tick();
    tick();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("rr_valid", cdb_valid, 1);
      chk("rr_tag", cdb_tag, exp_tags[c]);
      chk("rr_value", cdb_value, 32'h100 + (c % 4));
      for (int i = 0; i < N; i++) acc_cnt[i] += int'(fu_valid[i] & fu_ready[i]);
      tick();
    end
    for (int i = 0; i < N; i++) chk("rr_no_starve", acc_cnt[i] >= 1, 1);
    fu_valid = '0;
    repeat (6) tick();

    // Status-port conflict: issue to another register stalls the commit one cycle
    st_q = 3'd2;
    set_fu(1, 32'h55, 5'd5);
    fu_valid = 4'b0010;
    tick();
    fu_valid = '0;
    tick();
    iss_we = 1'b1; iss_num = 5'd7; iss_tag = 3'd6;
    @(negedge clk);
    chk("cf_valid", cdb_valid, 0);
    chk("cf_we", we, 0);
    chk("cf_we_rs", we_rs, 1);
    chk("cf_ws_rs", ws_rs, 7);
    chk("cf_wd_rs", wd_rs, 6);
    tick();
    iss_we = 1'b0;
    @(negedge clk);
    chk("cf2_valid", cdb_valid, 1);
    chk("cf2_tag", cdb_tag, 2);
    chk("cf2_value", cdb_value, 32'h55);
    chk("cf2_we", we, 1);
    chk("cf2_ws_rs", ws_rs, 5);
    chk("cf2_wd_rs", wd_rs, 0);
    tick();

    // Rename of the committing register: value written, no clear, no stall
    set_fu(1, 32'h77, 5'd5);
    fu_valid = 4'b0010;
    tick();
    fu_valid = '0;
    tick();
    iss_we = 1'b1; iss_num = 5'd5; iss_tag = 3'd3;
    @(negedge clk);
    chk("rn_valid", cdb_valid, 1);
    chk("rn_we", we, 1);
    chk("rn_ws", ws, 5);
    chk("rn_wd", wd, 32'h77);
    chk("rn_we_rs", we_rs, 1);
    chk("rn_ws_rs", ws_rs, 5);
    chk("rn_wd_rs", wd_rs, 3);
    tick();
    iss_we = 1'b0;
    @(negedge clk);
    chk("rn_after_valid", cdb_valid, 0);
    tick();

    // Asynchronous reset mid-cycle with stage and buffers full
    st_q = 3'd2;
    for (int i = 0; i < N; i++) set_fu(i, W'(32'h200 + i), R'(20 + i));
    fu_valid = '1;
    repeat (3) tick();
    @(negedge clk);
    #2;
    reset = 1'b1;
    fu_valid = '0;
    #1;
    chk("ar_cdb_valid", cdb_valid, 0);
    chk("ar_fu_ready", fu_ready, 4'hF);
    chk("ar_we", we, 0);
    chk("ar_we_rs", we_rs, 0);
    chk("ar_cdb_tag", cdb_tag, 0);
    chk("ar_cdb_value", cdb_value, 0);
    chk("ar_ws", ws, 0);
    chk("ar_wd", wd, 0);
    chk("ar_st_num", st_num, 0);
    tick();
    reset = 1'b0;
    single_result(2, 32'hC0FFEE, 5'd9, 3'd3, 1'b1, "post_rst");

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
